// File: rtl/spi_flash_read_seq.sv
// spi_flash_read_seq
//   Turns a read request (24-bit address, byte count) into a full SPI flash
//   read transaction. Drives the byte-level SPI shift engine via a start/done
//   handshake and owns chip-select. Read bytes are returned on a valid/ready stream.
//
//   Ports:
//     core_clk, core_rstn          clock, async active-low reset
//     req_valid/req_ready          request handshake; req_addr, req_len (, req_fast)
//     rsp_valid/rsp_ready          response handshake; rsp_data, rsp_last
//     busy                         high in any state other than IDLE
//     spi_csb                      flash chip select (active low, registered)
//     eng_start, eng_tx            engine byte launch (pulse) and byte to send
//     eng_done, eng_rx             engine byte completion (pulse) and received byte
//
//   Build option: define SPI_FAST_READ_EN to add the req_fast input. With
//   req_fast=1 the opcode is 0x0B and one dummy byte follows the address.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | csb high, accepting requests
//   CMD   | shifting the read opcode
//   A2    | shifting addr[23:16]
//   A1    | shifting addr[15:8]
//   A0    | shifting addr[7:0]
//   DUMMY | shifting the fast-read dummy byte
//   DATA  | shifting in read bytes into the response holding register
//   GAP   | csb high for CS_GAP cycles before the next request
module spi_flash_read_seq #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned CS_GAP   = 4,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
`ifdef SPI_FAST_READ_EN
  input  logic             req_fast,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             spi_csb,
  output logic             eng_start,
  output logic [7:0]       eng_tx,
  input  logic             eng_done,
  input  logic [7:0]       eng_rx
);

  localparam int unsigned GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [7:0]  FAST_CMD = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_DATA, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               issued_q, issued_d;
  logic               csb_q, csb_d;
  logic               start_q, start_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               rlast_q, rlast_d;
  logic               ready_q, ready_d;
  logic               use_fast;
  logic               is_byte;
  logic [7:0]         byte_tx;
  state_t             byte_next;

`ifdef SPI_FAST_READ_EN
  logic fast_q, fast_d;
  assign use_fast = fast_q;
`else
  assign use_fast = 1'b0;
`endif

  assign req_ready = ready_q;
  assign rsp_valid = rvalid_q;
  assign rsp_data  = rdata_q;
  assign rsp_last  = rlast_q;
  assign busy      = (state_q != S_IDLE);
  assign spi_csb   = csb_q;
  assign eng_start = start_q;
  assign eng_tx    = tx_q;

  always_comb begin
    is_byte   = 1'b0;
    byte_tx   = 8'h00;
    byte_next = S_IDLE;
    case (state_q)
      S_CMD: begin
        is_byte   = 1'b1;
        byte_tx   = use_fast ? FAST_CMD : READ_CMD;
        byte_next = S_A2;
      end
      S_A2: begin
        is_byte   = 1'b1;
        byte_tx   = addr_q[23:16];
        byte_next = S_A1;
      end
      S_A1: begin
        is_byte   = 1'b1;
        byte_tx   = addr_q[15:8];
        byte_next = S_A0;
      end
      S_A0: begin
        is_byte   = 1'b1;
        byte_tx   = addr_q[7:0];
        byte_next = use_fast ? S_DUMMY : S_DATA;
      end
      S_DUMMY: begin
        is_byte   = 1'b1;
        byte_next = S_DATA;
      end
      S_DATA: begin
        is_byte   = 1'b1;
        byte_next = S_DATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    issued_d = issued_q;
    csb_d    = csb_q;
    start_d  = 1'b0;
    tx_d     = tx_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
`ifdef SPI_FAST_READ_EN
    fast_d   = fast_q;
`endif

    if (rvalid_q && rsp_ready) begin
      rvalid_d = 1'b0;
    end

    if (state_q == S_IDLE) begin
      if (req_valid && ready_q) begin
        addr_d = req_addr;
        rem_d  = req_len;
`ifdef SPI_FAST_READ_EN
        fast_d = req_fast;
`endif
        if (req_len != '0) begin
          state_d  = S_CMD;
          csb_d    = 1'b0;
          issued_d = 1'b0;
        end
      end
    end else if (state_q == S_GAP) begin
      if (gap_q == '0) begin
        state_d = S_IDLE;
      end else begin
        gap_d = gap_q - GAP_W'(1);
      end
    end else if (is_byte) begin
      // A DATA byte may only be launched when the holding register will be
      // free by the time it completes; nothing else can fill it meanwhile.
      if (!issued_q && ((state_q != S_DATA) || !rvalid_q || rsp_ready)) begin
        start_d  = 1'b1;
        tx_d     = byte_tx;
        issued_d = 1'b1;
      end else if (issued_q && eng_done) begin
        issued_d = 1'b0;
        state_d  = byte_next;
        if (state_q == S_DATA) begin
          rdata_d  = eng_rx;
          rvalid_d = 1'b1;
          rlast_d  = (rem_q == LEN_W'(1));
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_GAP;
            csb_d   = 1'b1;
            gap_d   = GAP_W'(CS_GAP - 1);
          end
        end
      end
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      issued_q <= 1'b0;
      csb_q    <= 1'b1;
      start_q  <= 1'b0;
      tx_q     <= 8'h00;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      ready_q  <= 1'b0;
`ifdef SPI_FAST_READ_EN
      fast_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      issued_q <= issued_d;
      csb_q    <= csb_d;
      start_q  <= start_d;
      tx_q     <= tx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      ready_q  <= ready_d;
`ifdef SPI_FAST_READ_EN
      fast_q   <= fast_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Testbench for spi_flash_read_seq: a flash/engine model answers byte
// exchanges from a 256-byte aliased flash image; expected engine bytes and
// response bytes are queued at request time and checked by monitors.
module tb_spi_flash_read_seq;
  localparam int LEN_W  = 16;
  localparam int CS_GAP = 4;
`ifdef SPI_FAST_READ_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic             core_clk = 1'b0;
  logic             core_rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [23:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
`ifdef SPI_FAST_READ_EN
  logic             req_fast = 1'b0;
`endif
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic             rsp_last;
  logic             busy;
  logic             spi_csb;
  logic             eng_start;
  logic [7:0]       eng_tx;
  logic             eng_done = 1'b0;
  logic [7:0]       eng_rx = 8'h00;

  spi_flash_read_seq #(.LEN_W(LEN_W), .CS_GAP(CS_GAP), .READ_CMD(8'h03)) dut (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
`ifdef SPI_FAST_READ_EN
    .req_fast (req_fast),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .busy     (busy),
    .spi_csb  (spi_csb),
    .eng_start(eng_start),
    .eng_tx   (eng_tx),
    .eng_done (eng_done),
    .eng_rx   (eng_rx)
  );

  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int acc_cyc = 0;
  int fall_cyc = 0;
  int rdy_mode = 0;

  logic [7:0] img [256];
  logic [7:0] exp_tx_q [$];
  logic [7:0] exp_rd_q [$];
  bit         exp_last_q [$];

  always @(posedge core_clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response ready driver
  initial begin
    forever begin
      @(posedge core_clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Response monitor / scoreboard
  initial begin
    bit         prev_hold = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] e;
    bit         l;
    forever begin
      @(negedge core_clk);
      if (!core_rstn) begin
        prev_hold = 0;
      end else begin
        if (prev_hold)
          chk(rsp_valid && (rsp_data == prev_data), "rsp_hold", {rsp_valid, rsp_data}, {1'b1, prev_data});
        if (rsp_valid && rsp_ready) begin
          if (exp_rd_q.size() == 0) begin
            chk(0, "rsp_unexpected", rsp_data, 0);
          end else begin
            e = exp_rd_q.pop_front();
            l = exp_last_q.pop_front();
            chk((rsp_data == e) && (rsp_last == l), "rsp_data_last", {rsp_last, rsp_data}, {l, e});
          end
        end
        prev_hold = rsp_valid && !rsp_ready;
        prev_data = rsp_data;
      end
    end
  end

  // Chip-select gap and acceptance timing monitor
  initial begin
    bit prev_csb = 1;
    bit seen_low = 0;
    int hi_cnt = 0;
    forever begin
      @(negedge core_clk);
      if (!core_rstn) begin
        prev_csb = 1;
        seen_low = 0;
        hi_cnt = 0;
      end else begin
        if (req_valid && req_ready && (req_len != 0)) acc_cyc = cyc;
        if (!spi_csb && prev_csb) begin
          if (seen_low) chk(hi_cnt >= CS_GAP, "cs_gap", hi_cnt, CS_GAP);
          fall_cyc = cyc;
          seen_low = 1;
          hi_cnt = 0;
        end
        if (spi_csb) hi_cnt++;
        prev_csb = spi_csb;
      end
    end
  end

  // SPI engine + flash model: the flash decodes opcode/address from the
  // shifted bytes and returns auto-incrementing data from the image.
  initial begin
    int k = 0;
    int first;
    int d;
    bit abort;
    logic [7:0]  op = 8'h00;
    logic [23:0] fa = '0;
    logic [7:0]  tx, rx, e, idx;
    forever begin
      @(negedge core_clk);
      if (spi_csb) k = 0;
      if (core_rstn && eng_start) begin
        starts++;
        chk(!spi_csb, "csb_low_at_start", spi_csb, 0);
        if (k == 0) begin
          chk(cyc - acc_cyc == 2, "start_latency", cyc - acc_cyc, 2);
          chk(cyc - fall_cyc == 1, "csb_lead", cyc - fall_cyc, 1);
        end
        if (exp_tx_q.size() == 0) begin
          chk(0, "tx_unexpected", eng_tx, 0);
        end else begin
          e = exp_tx_q.pop_front();
          chk(eng_tx == e, "eng_tx", eng_tx, e);
        end
        tx = eng_tx;
        if (k == 0) op = tx;
        else if (k <= 3) fa = {fa[15:0], tx};
        first = (op == 8'h0B) ? 5 : 4;
        if (k >= first) begin
          idx = fa[7:0] + 8'(k - first);
          rx = img[idx];
        end else begin
          rx = 8'($urandom);
        end
        k++;
        d = $urandom_range(0, 3);
        abort = 0;
        for (int i = 0; i <= d; i++) begin
          @(posedge core_clk);
          #1;
          if (!core_rstn) begin
            abort = 1;
            break;
          end
        end
        if (!abort) begin
          chk(eng_tx == tx, "tx_stable", eng_tx, tx);
          eng_done = 1'b1;
          eng_rx = rx;
          @(posedge core_clk);
          #1;
          eng_done = 1'b0;
          eng_rx = 8'h00;
        end
      end
    end
  end

  task automatic issue(input logic [23:0] addr, input int len, input bit fast);
    int n = 0;
    bit f;
    logic [7:0] a;
    f = fast & FAST_EN;
    @(posedge core_clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = LEN_W'(len);
`ifdef SPI_FAST_READ_EN
    req_fast  = f;
`endif
    forever begin
      @(negedge core_clk);
      if (req_ready) break;
      n++;
      if (n > 2000) begin
        chk(0, "req_timeout", n, 2000);
        req_valid = 1'b0;
        return;
      end
    end
    if (len != 0) begin
      exp_tx_q.push_back(f ? 8'h0B : 8'h03);
      exp_tx_q.push_back(addr[23:16]);
      exp_tx_q.push_back(addr[15:8]);
      exp_tx_q.push_back(addr[7:0]);
      if (f) exp_tx_q.push_back(8'h00);
      for (int i = 0; i < len; i++) begin
        a = addr[7:0] + 8'(i);
        exp_tx_q.push_back(8'h00);
        exp_rd_q.push_back(img[a]);
        exp_last_q.push_back(i == len - 1);
      end
    end
    @(posedge core_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit ok = 0;
    while (n < 5000) begin
      @(negedge core_clk);
      if (!busy && !rsp_valid && exp_rd_q.size() == 0 && exp_tx_q.size() == 0) begin
        ok = 1;
        break;
      end
      n++;
    end
    chk(ok, "idle_timeout", n, 5000);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    bit ok;
    logic [23:0] ra;
    int rl;

    img[0] = 8'h93; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h13;
    img[4] = 8'h02; img[5] = 8'h63; img[6] = 8'h57; img[7] = 8'hb5;
    for (int i = 8; i < 256; i++) img[i] = 8'($urandom);

    // Reset values
    repeat (3) @(posedge core_clk);
    #1;
    chk(!req_ready && !rsp_valid && !rsp_last && !busy, "reset_ctrl",
        {req_ready, rsp_valid, rsp_last, busy}, 0);
    chk(spi_csb && !eng_start, "reset_spi", {spi_csb, eng_start}, 2'b10);
    chk((rsp_data == 8'h00) && (eng_tx == 8'h00), "reset_data", {rsp_data, eng_tx}, 0);
    @(negedge core_clk);
    core_rstn = 1'b1;

    // Basic read, ready tied high
    rdy_mode = 0;
    issue(24'h000000, 4, 0);
    wait_idle();

    // Stalled consumer
    rdy_mode = 2;
    issue(24'h000004, 4, 0);
    n = 0;
    ok = 0;
    while (n < 500) begin
      @(negedge core_clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      n++;
    end
    chk(ok, "stall_first_byte", n, 500);
    s0 = starts;
    repeat (20) @(negedge core_clk);
    chk(starts - s0 <= 1, "stall_starts", starts - s0, 1);
    chk(rsp_valid, "stall_valid_held", rsp_valid, 1);
    rdy_mode = 0;
    wait_idle();

    // Zero-length request
    issue(24'h000055, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge core_clk);
      chk(spi_csb && !eng_start && !busy && !rsp_valid && req_ready, "len0_quiet",
          {spi_csb, eng_start, busy, rsp_valid, req_ready}, 5'b10001);
    end

    // Reset while the A1 byte is in flight
    s0 = starts;
    issue(24'h123456, 4, 0);
    n = 0;
    while ((starts < s0 + 3) && (n < 500)) begin
      @(negedge core_clk);
      #2;
      n++;
    end
    chk(starts == s0 + 3, "reach_a1", starts - s0, 3);
    core_rstn = 1'b0;
    #1;
    chk(spi_csb && !rsp_valid && !eng_start && !busy, "async_reset",
        {spi_csb, rsp_valid, eng_start, busy}, 4'b1000);
    exp_tx_q.delete();
    exp_rd_q.delete();
    exp_last_q.delete();
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    core_rstn = 1'b1;
    issue(24'h000000, 1, 0);
    wait_idle();

    // Back-to-back requests
    issue(24'h000000, 1, 0);
    issue(24'h000001, 1, 0);
    wait_idle();

    // Address wrap with random consumer
    rdy_mode = 1;
    issue(24'hFFFFFE, 4, 0);
    wait_idle();

    // Fast read
    rdy_mode = 0;
    if (FAST_EN) begin
      issue(24'h000000, 2, 1);
      wait_idle();
    end

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      rdy_mode = $urandom_range(0, 1);
      ra = 24'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 24'hFFFFF8 + 24'($urandom_range(0, 7));
      rl = $urandom_range(0, 6);
      issue(ra, rl, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    rdy_mode = 0;
    wait_idle();
    chk(exp_rd_q.size() == 0, "rsp_queue_drained", exp_rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
